// File: rtl/tone_period_detector.sv
// Square-wave tone period detector: measures the half-period between input transitions,
// converts it back to the generator's switch-period value and locks after repeated agreement.
module tone_period_detector #(
    parameter int MATCH_COUNT    = 3,
    parameter int TOLERANCE      = 2,
    parameter int TIMEOUT_CYCLES = 16_777_218
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        square_wave_in,
    output logic [23:0] measured_period,
    output logic        period_valid,
    output logic        period_update
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        TRACKING = 2'd2,
        LOCKED   = 2'd3
    } state_t;

    localparam logic [24:0] CNT_MAX = 25'(TIMEOUT_CYCLES - 1);
    localparam logic [24:0] TOL     = 25'(TOLERANCE);
    localparam logic [3:0]  LOCK_AT = 4'(MATCH_COUNT);

    function automatic logic [24:0] sat_inc(input logic [24:0] c);
        return (c == CNT_MAX) ? c : c + 25'd1;
    endfunction

    function automatic logic [24:0] abs_diff(input logic [23:0] a, input logic [23:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    logic        r_s1, r_s2, r_s3;
    logic [24:0] r_cnt;
    state_t      r_state;
    logic [3:0]  r_match_cnt;
    logic [23:0] r_ref;
    logic [23:0] r_measured_period;
    logic        r_period_valid;
    logic        r_period_update;

    logic        w_edge;
    logic        w_glitch;
    logic [23:0] w_cand;
    logic [23:0] w_ref;
    logic        w_match;
    logic        w_timeout;
    logic [3:0]  w_match_inc;
    state_t      w_state_nx;
    logic [3:0]  w_match_cnt_nx;
    logic [23:0] w_ref_nx;
    logic [23:0] w_meas_nx;
    logic        w_update_nx;

    assign w_edge      = r_s2 ^ r_s3;
    // Interval H = cnt+1; the generator's half-period is P+2, so P = cnt-1.
    assign w_cand      = r_cnt[23:0] - 24'd1;
    assign w_glitch    = (r_cnt < 25'd2);
    assign w_ref       = (r_state == LOCKED) ? r_measured_period : r_ref;
    assign w_match     = (abs_diff(w_cand, w_ref) <= TOL);
    assign w_timeout   = !w_edge && (r_cnt == CNT_MAX) && (r_state != IDLE);
    assign w_match_inc = r_match_cnt + 4'd1;

    always_comb begin
        w_state_nx     = r_state;
        w_match_cnt_nx = r_match_cnt;
        w_ref_nx       = r_ref;
        w_meas_nx      = r_measured_period;
        w_update_nx    = 1'b0;
        if (w_edge) begin
            case (r_state)
                IDLE: begin
                    w_state_nx = ARMED;
                end
                ARMED: begin
                    if (!w_glitch) begin
                        w_state_nx     = TRACKING;
                        w_ref_nx       = w_cand;
                        w_match_cnt_nx = 4'd1;
                    end
                end
                TRACKING: begin
                    if (w_glitch) begin
                        w_state_nx     = ARMED;
                        w_match_cnt_nx = 4'd0;
                    end else if (w_match) begin
                        w_ref_nx       = w_cand;
                        w_match_cnt_nx = w_match_inc;
                        if (w_match_inc == LOCK_AT) begin
                            w_state_nx  = LOCKED;
                            w_meas_nx   = w_cand;
                            w_update_nx = 1'b1;
                        end
                    end else begin
                        w_ref_nx       = w_cand;
                        w_match_cnt_nx = 4'd1;
                    end
                end
                LOCKED: begin
                    if (w_glitch) begin
                        w_state_nx     = ARMED;
                        w_match_cnt_nx = 4'd0;
                    end else if (w_match) begin
                        w_ref_nx    = w_cand;
                        w_meas_nx   = w_cand;
                        w_update_nx = 1'b1;
                    end else begin
                        w_state_nx     = TRACKING;
                        w_ref_nx       = w_cand;
                        w_match_cnt_nx = 4'd1;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nx     = IDLE;
            w_meas_nx      = 24'd0;
            w_match_cnt_nx = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1              <= 1'b0;
            r_s2              <= 1'b0;
            r_s3              <= 1'b0;
            r_cnt             <= '0;
            r_state           <= IDLE;
            r_match_cnt       <= '0;
            r_ref             <= '0;
            r_measured_period <= '0;
            r_period_valid    <= 1'b0;
            r_period_update   <= 1'b0;
        end else begin
            r_s1              <= square_wave_in;
            r_s2              <= r_s1;
            r_s3              <= r_s2;
            r_cnt             <= w_edge ? 25'd0 : sat_inc(r_cnt);
            r_state           <= w_state_nx;
            r_match_cnt       <= w_match_cnt_nx;
            r_ref             <= w_ref_nx;
            r_measured_period <= w_meas_nx;
            r_period_valid    <= (w_state_nx == LOCKED);
            r_period_update   <= w_update_nx;
        end
    end

    assign measured_period = r_measured_period;
    assign period_valid    = r_period_valid;
    assign period_update   = r_period_update;

endmodule

// File: tb/tb_tone_period_detector.sv
// Bench for tone_period_detector: hand-computed vector table, corner sequences and a
// timestamp-based reference model checked on every clock.
module tb_tone_period_detector;

    localparam int MC  = 3;
    localparam int TOL = 2;
    localparam int TO  = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        square_wave_in;
    logic [23:0] measured_period;
    logic        period_valid;
    logic        period_update;

    tone_period_detector #(
        .MATCH_COUNT   (MC),
        .TOLERANCE     (TOL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .square_wave_in (square_wave_in),
        .measured_period(measured_period),
        .period_valid   (period_valid),
        .period_update  (period_update)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int upd_seen = 0;
    int last_tog_cyc = 0;
    bit level = 1'b0;

    // Reference model: the detector as seen from outside, driven by clock timestamps.
    typedef enum int {M_IDLE, M_ARMED, M_TRACK, M_LOCKED} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_last_edge = 0;
    int      m_ref = 0;
    int      m_mc  = 0;
    int      m_mp  = 0;
    bit      m_upd = 1'b0;
    bit      hist[$];   // input value as seen by the detector at each clock

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    function automatic void model_step(input bit r, input bit v);
        int n, h, cand, refv, diff;
        bit edge_seen, glitch, match;
        m_upd = 1'b0;
        if (r) begin
            // Reset also wipes the samples already in flight.
            hist.push_back(1'b0);
            n = hist.size();
            hist[n-2] = 1'b0;
            hist[n-3] = 1'b0;
            m_state = M_IDLE;
            m_last_edge = cyc;
            m_ref = 0;
            m_mc  = 0;
            m_mp  = 0;
        end else begin
            hist.push_back(v);
            n = hist.size();
            // A transition sampled at clock k is acted upon at clock k+2.
            edge_seen = (hist[n-3] != hist[n-4]);
            h = cyc - m_last_edge;
            if (edge_seen) begin
                cand   = (h - 2) & 32'h00FF_FFFF;
                glitch = (h < 3);
                refv   = (m_state == M_LOCKED) ? m_mp : m_ref;
                diff   = (cand > refv) ? cand - refv : refv - cand;
                match  = (diff <= TOL);
                case (m_state)
                    M_IDLE: m_state = M_ARMED;
                    M_ARMED: begin
                        if (!glitch) begin
                            m_state = M_TRACK;
                            m_ref = cand;
                            m_mc = 1;
                        end
                    end
                    M_TRACK: begin
                        if (glitch) begin
                            m_state = M_ARMED;
                            m_mc = 0;
                        end else if (match) begin
                            m_mc = m_mc + 1;
                            m_ref = cand;
                            if (m_mc == MC) begin
                                m_state = M_LOCKED;
                                m_mp = cand;
                                m_upd = 1'b1;
                            end
                        end else begin
                            m_ref = cand;
                            m_mc = 1;
                        end
                    end
                    default: begin
                        if (glitch) begin
                            m_state = M_ARMED;
                            m_mc = 0;
                        end else if (match) begin
                            m_mp = cand;
                            m_ref = cand;
                            m_upd = 1'b1;
                        end else begin
                            m_state = M_TRACK;
                            m_ref = cand;
                            m_mc = 1;
                        end
                    end
                endcase
                m_last_edge = cyc;
            end else if (m_state != M_IDLE && h >= TO) begin
                m_state = M_IDLE;
                m_mp = 0;
                m_mc = 0;
            end
        end
        if (hist.size() > 8) hist.delete(0);
    endfunction

    task automatic tick(input bit r, input bit v);
        rst = r;
        square_wave_in = v;
        @(posedge clk);
        cyc++;
        model_step(r, v);
        #1;
        if (period_update) upd_seen++;
        check("measured_period", measured_period, m_mp);
        check("period_valid", period_valid, (m_state == M_LOCKED) ? 1 : 0);
        check("period_update", period_update, m_upd);
    endtask

    // Generator-like stimulus: n transitions, each level held for p+2 clocks.
    task automatic gen(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            level = ~level;
            last_tog_cyc = cyc + 1;
            repeat (p + 2) tick(1'b0, level);
        end
    endtask

    typedef struct {
        int p;
        int n;
        int exp_mp;
        bit exp_valid;
        int exp_upd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int fall;
        int longs;
        int base;
        int kind;
        int hold;

        // Applied in order; the first interval of each row is the previous row's half-period.
        vecs[0] = '{10,  4, 10, 1'b1, 1};  // arm, track, match, lock at 10
        vecs[1] = '{10,  2, 10, 1'b1, 2};  // locked, updates on every transition
        vecs[2] = '{100, 2, 10, 1'b0, 1};  // one more 12, then 102 drops lock, value held
        vecs[3] = '{100, 2, 100, 1'b1, 1}; // relock at 100
        vecs[4] = '{50,  4, 50, 1'b1, 2};  // 102 matches, 52 mismatch, relock at 50
        vecs[5] = '{52,  2, 52, 1'b1, 2};  // +2 jitter stays locked and updates
        vecs[6] = '{49,  2, 52, 1'b0, 1};  // -3 jitter drops to tracking

        rst = 1'b1;
        square_wave_in = 1'b0;
        repeat (4) hist.push_back(1'b0);

        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("reset measured_period", measured_period, 0);
        check("reset period_valid", period_valid, 0);
        check("reset period_update", period_update, 0);
        repeat (5) tick(1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            upd_seen = 0;
            gen(vecs[i].p, vecs[i].n);
            check($sformatf("vec%0d measured_period", i), measured_period, vecs[i].exp_mp);
            check($sformatf("vec%0d period_valid", i), period_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d update pulses", i), upd_seen, vecs[i].exp_upd);
        end

        // Glitch while tracking: 51 matches (count 2), then a 1-cycle pulse rearms.
        level = ~level;
        tick(1'b0, level);
        level = ~level;
        repeat (22) tick(1'b0, level);
        check("glitch no lock", period_valid, 0);
        gen(20, 2);
        check("glitch count cleared", period_valid, 0);
        gen(20, 1);
        check("glitch relock valid", period_valid, 1);
        check("glitch relock value", measured_period, 20);

        // Silence while locked at 20: drop one clock after the counter reaches TO-1.
        fall = -1;
        for (int k = 0; k < TO + 50; k++) begin
            tick(1'b0, level);
            if (!period_valid) begin
                fall = cyc;
                break;
            end
        end
        check("timeout latency", fall - (last_tog_cyc + 2), TO);
        check("timeout measured_period", measured_period, 0);

        // Reset while locked at 7, then relock needs four fresh transitions.
        gen(7, 4);
        check("lock at 7 valid", period_valid, 1);
        check("lock at 7 value", measured_period, 7);
        if (level) gen(7, 1);
        tick(1'b1, level);
        check("midrun reset measured_period", measured_period, 0);
        check("midrun reset period_valid", period_valid, 0);
        check("midrun reset period_update", period_update, 0);
        gen(7, 3);
        check("three transitions no lock", period_valid, 0);
        level = ~level;
        tick(1'b0, level);
        check("fourth transition +0", period_valid, 0);
        tick(1'b0, level);
        check("fourth transition +1", period_valid, 0);
        tick(1'b0, level);
        check("fourth transition +2 valid", period_valid, 1);
        check("fourth transition +2 value", measured_period, 7);
        check("fourth transition +2 update", period_update, 1);
        repeat (6) tick(1'b0, level);

        // Randomized traffic against the model.
        longs = 0;
        base = 20;
        for (int it = 0; it < 120; it++) begin
            kind = $urandom_range(0, 11);
            if (kind == 0) begin
                level = ~level;
                tick(1'b0, level);
                level = ~level;
                hold = $urandom_range(3, 30);
                repeat (hold) tick(1'b0, level);
            end else if (kind == 1 && longs < 2) begin
                longs++;
                repeat (TO + 5) tick(1'b0, level);
            end else if (kind == 2) begin
                tick(1'b1, level);
            end else if (kind == 3) begin
                base = $urandom_range(1, 60);
            end else begin
                level = ~level;
                hold = base + $urandom_range(0, 4);
                repeat (hold) tick(1'b0, level);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
